elastic_pipe_register: RTL and testbench
========================================

// Module: elastic_pipe_register
//
// PURPOSE
// - Parametrised successor to the single enable-gated register: a DEPTH-stage pipeline register of WIDTH-bit words.
// - Uses a valid/ready handshake per stage, so back-pressure stalls the pipeline without losing data.
// - Bubbles collapse: an empty stage fills even while downstream stages are stalled.
// - Sits between RSNN datapath blocks (e.g. neuron-state update -> spike encoder) to retime paths and absorb stalls.
//
// PARAMETERS
// - WIDTH  3  bits per data word; >= 1
// - DEPTH  2  number of pipeline stages; >= 1
// - CNT_W  $clog2(DEPTH+1)  width of occupancy output (localparam, derived; not overridable)
//
// PORTS
// - clk        in   1       single clock; all state updates on posedge
// - reset      in   1       synchronous, active-high; sampled on posedge clk only
// - flush      in   1       synchronous clear of all stage valids; data unchanged
// - in_valid   in   1       upstream word present on in_data
// - in_ready   out  1       stage 0 can accept this cycle (combinational)
// - in_data    in   WIDTH   upstream word
// - out_valid  out  1       word present on out_data (= valid of stage DEPTH-1)
// - out_ready  in   1       downstream accepts out_data this cycle
// - out_data   out  WIDTH   data of stage DEPTH-1 (registered)
// - occupancy  out  CNT_W   number of valid stages, 0..DEPTH (registered)
//
// BEHAVIOUR
// - Per stage i: valid bit v[i] and data register d[i].
// - Advance terms (combinational):
//   - adv[DEPTH-1] = v[DEPTH-1] & out_ready
//   - adv[i] = v[i] & (~v[i+1] | adv[i+1])
// - Accept terms:
//   - Stage i+1 loads d[i] when adv[i].
//   - in_ready = ~v[0] | adv[0]; stage 0 loads in_data when in_valid & in_ready.
// - Valid update: v[i] <= load[i] | (v[i] & ~adv[i]).
// - Ready path: the combinational chain from out_ready to in_ready is intentional; no skid buffer. Full throughput: one word per cycle when never stalled.
// - Latency: a word accepted at edge N is presented at out_valid after edge N+DEPTH-1, so it is visible in cycle N+DEPTH when there are no stalls.
// - Ordering: strictly FIFO; no word is dropped or duplicated.
// - d[i] holds its value unless loaded; no enable-less overwrite.
// - Occupancy: registered count of set v[i].
//   - Next value = occ + (in_valid & in_ready) - (out_valid & out_ready).
//   - Must always equal popcount(v).
// - Reset (sync): all v <= 0, all d <= 0, occupancy <= 0.
//   - Therefore out_valid = 0 and out_data = 0 after the reset edge.
//   - in_ready = 1 in the first cycle after reset.
//   - Reset overrides flush and any handshake in the same cycle.
//   - Reset mid-stream discards all in-flight words.
// - Flush: all v <= 0 and occupancy <= 0 on the edge.
//   - A word offered with in_valid in the flush cycle is NOT captured, even though in_ready may read 1.
//   - out_valid & out_ready in the flush cycle counts as delivered: the downstream takes the word.
// - Full (occupancy == DEPTH) with out_ready = 0: in_ready = 0 and all stages hold.
// - Full with out_ready = 1: in_ready = 1 and simultaneous in/out keeps occupancy == DEPTH.
// - Empty: out_valid = 0; out_data holds its last value and is don't-care for the consumer.
// - DEPTH = 1: degenerates to a one-entry register with in_ready = ~v[0] | out_ready.
// - X-safety: in_data is not propagated into v; in_valid must be known whenever reset = 0.
//
// STRUCTURE
// - Shared header rsnn_defs.vh holds:
//   - `define RSNN_CLOG2 helper (if the tool lacks $clog2)
//   - default WIDTH constants used across RSNN blocks
// - Sub-module pipe_stage #(WIDTH): one v/d pair with load/adv logic.
//   - Instantiated DEPTH times in a generate loop.
//   - Top level holds the advance chain and the occupancy counter.
// - No FSM beyond per-stage valid bits; the occupancy counter is the only arithmetic.
//
// TESTING
// - Reset: WIDTH=3, DEPTH=2; drive garbage, then assert reset for one edge.
//   -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
// - Streaming: out_ready=1 held; send 1,2,3,4,5 on consecutive cycles.
//   -> out sequence 1..5, first appearing 2 cycles after acceptance, no gaps.
//   -> occupancy settles at 2.
// - Back-pressure: out_ready=0; send 6,7,8.
//   -> 6 and 7 accepted, occupancy=2, in_ready=0 while 8 is held.
//   -> Raise out_ready: outputs 6,7,8 in order with no loss.
// - Bubble collapse: DEPTH=4; word A, gap, word B with out_ready=0.
//   -> A and B in adjacent stages, occupancy=2, in_ready=1.
// - Flush: DEPTH=4 full with words 9..12; flush=1 with in_valid=1, in_data=13.
//   -> Next cycle occupancy=0, out_valid=0; 13 never appears at the output.
// - Random: random in_valid/out_ready for 10k cycles, DEPTH in {1,3,8}, WIDTH=8.
//   -> Scoreboard matches FIFO order.
//   -> occupancy == popcount(v) and never exceeds DEPTH.

Source files
------------

// File: rtl/elastic_pipe_register_pkg.sv
// Shared constants and helpers for the elastic pipeline register and its stages.
package elastic_pipe_register_pkg;

   localparam int unsigned RsnnDefaultWidth = 3;
   localparam int unsigned RsnnDefaultDepth = 2;

   // Occupancy counter width for a pipe that holds 0..depth words.
   function automatic int unsigned occ_width(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_pipe_register_pipe_stage.sv
// One pipeline stage: a valid bit and a data word that only changes when the stage loads.
module elastic_pipe_register_pipe_stage
   import elastic_pipe_register_pkg::*;
#(
   parameter int unsigned WIDTH = RsnnDefaultWidth
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   // Flush drops the valid bits but leaves the data words untouched.
   always_comb begin
      valid_d = (load_i | (valid_q & ~adv_i)) & ~flush_i;
      data_d  = (load_i & ~flush_i) ? data_i : data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_register.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse and a registered occupancy count.
module elastic_pipe_register
   import elastic_pipe_register_pkg::*;
#(
   parameter int unsigned WIDTH = RsnnDefaultWidth,
   parameter int unsigned DEPTH = RsnnDefaultDepth
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int unsigned CNT_W = occ_width(DEPTH);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] stage_din  [DEPTH];
   logic [WIDTH-1:0] stage_dout [DEPTH];
   logic             push, pop;
   logic [CNT_W-1:0] occ_d, occ_q;

   assign adv[DEPTH-1] = valid[DEPTH-1] & out_ready;
   assign in_ready     = ~valid[0] | adv[0];
   assign push         = in_valid & in_ready;
   assign pop          = valid[DEPTH-1] & out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i < DEPTH - 1) begin : g_adv
         // Unrolled advance chain: a valid stage moves if any later stage is empty or the
         // output drains this cycle.
         assign adv[i] = valid[i] & (out_ready | ~(&valid[DEPTH-1:i+1]));
      end

      if (i == 0) begin : g_head
         assign load[i]      = push;
         assign stage_din[i] = in_data;
      end else begin : g_body
         assign load[i]      = adv[i-1];
         assign stage_din[i] = stage_dout[i-1];
      end

      elastic_pipe_register_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush_i (flush),
         .load_i  (load[i]),
         .adv_i   (adv[i]),
         .data_i  (stage_din[i]),
         .valid_o (valid[i]),
         .data_o  (stage_dout[i])
      );
   end

   always_comb begin
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
      if (flush) begin
         occ_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign out_valid = valid[DEPTH-1];
   assign out_data  = stage_dout[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Scoreboard bench for elastic_pipe_register: directed scenarios on DEPTH 2/4, random on 1/3/8.
module tb_elastic_pipe_register;

   logic       clk = 1'b0;
   logic       reset, flush, in_valid, out_ready;
   logic [7:0] in_data;
   int         n_checks = 0;
   int         n_fail = 0;
   int         edge_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // DEPTH=2, WIDTH=3
   logic       d2_in_ready, d2_out_valid;
   logic [2:0] d2_out_data;
   logic [1:0] d2_occ;
   // DEPTH=4, WIDTH=8
   logic       d4_in_ready, d4_out_valid;
   logic [7:0] d4_out_data;
   logic [2:0] d4_occ;
   // Random configs DEPTH 1/3/8, WIDTH=8
   logic       r_in_ready  [3];
   logic       r_out_valid [3];
   logic [7:0] r_out_data  [3];
   logic [3:0] r_occ       [3];
   logic [0:0] o1;
   logic [1:0] o3;
   logic [3:0] o8;

   assign r_occ[0] = {3'b000, o1};
   assign r_occ[1] = {2'b00, o3};
   assign r_occ[2] = o8;

   elastic_pipe_register #(.WIDTH(3), .DEPTH(2)) u_d2 (
      .clk (clk), .reset (reset), .flush (flush), .in_valid (in_valid),
      .in_ready (d2_in_ready), .in_data (in_data[2:0]), .out_valid (d2_out_valid),
      .out_ready (out_ready), .out_data (d2_out_data), .occupancy (d2_occ)
   );
   elastic_pipe_register #(.WIDTH(8), .DEPTH(4)) u_d4 (
      .clk (clk), .reset (reset), .flush (flush), .in_valid (in_valid),
      .in_ready (d4_in_ready), .in_data (in_data), .out_valid (d4_out_valid),
      .out_ready (out_ready), .out_data (d4_out_data), .occupancy (d4_occ)
   );
   elastic_pipe_register #(.WIDTH(8), .DEPTH(1)) u_r1 (
      .clk (clk), .reset (reset), .flush (flush), .in_valid (in_valid),
      .in_ready (r_in_ready[0]), .in_data (in_data), .out_valid (r_out_valid[0]),
      .out_ready (out_ready), .out_data (r_out_data[0]), .occupancy (o1)
   );
   elastic_pipe_register #(.WIDTH(8), .DEPTH(3)) u_r3 (
      .clk (clk), .reset (reset), .flush (flush), .in_valid (in_valid),
      .in_ready (r_in_ready[1]), .in_data (in_data), .out_valid (r_out_valid[1]),
      .out_ready (out_ready), .out_data (r_out_data[1]), .occupancy (o3)
   );
   elastic_pipe_register #(.WIDTH(8), .DEPTH(8)) u_r8 (
      .clk (clk), .reset (reset), .flush (flush), .in_valid (in_valid),
      .in_ready (r_in_ready[2]), .in_data (in_data), .out_valid (r_out_valid[2]),
      .out_ready (out_ready), .out_data (r_out_data[2]), .occupancy (o8)
   );

   // Scoreboard: expected word and the edge on which it was accepted.
   logic [7:0] sbq [$];
   int         sbt [$];
   logic [7:0] rq  [3][$];
   int         rt  [3][$];

   function automatic int rdep(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 8);
   endfunction

   task automatic pulse_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      sbq.delete(); sbt.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'($urandom);
         @(posedge clk); #1;
      end
      // Reset must win over flush and a live handshake.
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hff;
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (d2_out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_d2_out_valid: got %b want 0", d2_out_valid); end
      n_checks++; if (d2_out_data !== 3'd0) begin n_fail++;
         $display("FAIL reset_d2_out_data: got %0d want 0", d2_out_data); end
      n_checks++; if (d2_occ !== 2'd0) begin n_fail++;
         $display("FAIL reset_d2_occupancy: got %0d want 0", d2_occ); end
      n_checks++; if (d2_in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_d2_in_ready: got %b want 1", d2_in_ready); end
      n_checks++; if (d4_out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_d4_out_valid: got %b want 0", d4_out_valid); end
      n_checks++; if (d4_out_data !== 8'd0) begin n_fail++;
         $display("FAIL reset_d4_out_data: got %0d want 0", d4_out_data); end
      n_checks++; if (d4_occ !== 3'd0) begin n_fail++;
         $display("FAIL reset_d4_occupancy: got %0d want 0", d4_occ); end
      n_checks++; if (d4_in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_d4_in_ready: got %b want 1", d4_in_ready); end
      sbq.delete(); sbt.delete();
      @(posedge clk); #1;
   endtask

   task automatic test_streaming();
      int   sent = 0;
      int   got = 0;
      logic exp_rdy, exp_ov, push, pop;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
         in_valid = (sent < 5);
         in_data  = 8'(sent + 1);
         @(negedge clk);
         exp_rdy = (sbq.size() < 2) || out_ready;
         exp_ov  = (sbq.size() > 0) && (edge_cnt - sbt[0] >= 1);
         n_checks++; if (d2_in_ready !== exp_rdy) begin n_fail++;
            $display("FAIL stream_in_ready cyc %0d: got %b want %b", cyc, d2_in_ready, exp_rdy); end
         n_checks++; if (d2_out_valid !== exp_ov) begin n_fail++;
            $display("FAIL stream_out_valid cyc %0d: got %b want %b", cyc, d2_out_valid, exp_ov); end
         if (exp_ov) begin
            n_checks++; if (d2_out_data !== sbq[0][2:0]) begin n_fail++;
               $display("FAIL stream_out_data cyc %0d: got %0d want %0d", cyc, d2_out_data,
                        sbq[0][2:0]); end
         end
         n_checks++; if (d2_occ !== 2'(sbq.size())) begin n_fail++;
            $display("FAIL stream_occupancy cyc %0d: got %0d want %0d", cyc, d2_occ, sbq.size()); end
         push = in_valid && exp_rdy;
         pop  = exp_ov && out_ready;
         @(posedge clk); #1;
         if (pop) begin void'(sbq.pop_front()); void'(sbt.pop_front()); got++; end
         if (push) begin sbq.push_back(in_data); sbt.push_back(edge_cnt); sent++; end
      end
      in_valid = 1'b0;
      n_checks++; if (got != 5) begin n_fail++;
         $display("FAIL stream_delivered: got %0d words want 5", got); end
   endtask

   task automatic test_back_pressure();
      logic [7:0] words [3] = '{8'd6, 8'd7, 8'd8};
      int   sent = 0;
      int   got = 0;
      logic exp_rdy, exp_ov, push, pop;
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
         out_ready = (cyc >= 6);
         in_valid  = (sent < 3);
         in_data   = (sent < 3) ? words[sent] : 8'd0;
         @(negedge clk);
         exp_rdy = (sbq.size() < 2) || out_ready;
         exp_ov  = (sbq.size() > 0) && (edge_cnt - sbt[0] >= 1);
         if (cyc == 5) begin
            n_checks++; if (d2_in_ready !== 1'b0 || d2_occ !== 2'd2) begin n_fail++;
               $display("FAIL bp_full_hold: got in_ready=%b occ=%0d want in_ready=0 occ=2",
                        d2_in_ready, d2_occ); end
         end
         n_checks++; if (d2_in_ready !== exp_rdy) begin n_fail++;
            $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, d2_in_ready, exp_rdy); end
         n_checks++; if (d2_out_valid !== exp_ov) begin n_fail++;
            $display("FAIL bp_out_valid cyc %0d: got %b want %b", cyc, d2_out_valid, exp_ov); end
         if (exp_ov) begin
            n_checks++; if (d2_out_data !== sbq[0][2:0]) begin n_fail++;
               $display("FAIL bp_out_data cyc %0d: got %0d want %0d", cyc, d2_out_data,
                        sbq[0][2:0]); end
         end
         n_checks++; if (d2_occ !== 2'(sbq.size())) begin n_fail++;
            $display("FAIL bp_occupancy cyc %0d: got %0d want %0d", cyc, d2_occ, sbq.size()); end
         push = in_valid && exp_rdy;
         pop  = exp_ov && out_ready;
         @(posedge clk); #1;
         if (pop) begin void'(sbq.pop_front()); void'(sbt.pop_front()); got++; end
         if (push) begin sbq.push_back(in_data); sbt.push_back(edge_cnt); sent++; end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_checks++; if (got != 3) begin n_fail++;
         $display("FAIL bp_delivered: got %0d words want 3", got); end
   endtask

   task automatic test_bubble_collapse();
      int   got = 0;
      logic exp_rdy, exp_ov, push, pop;
      pulse_reset();
      for (int cyc = 0; cyc < 30 && !(cyc > 8 && sbq.size() == 0); cyc++) begin
         out_ready = (cyc >= 8);
         in_valid  = (cyc == 0) || (cyc == 2);
         in_data   = (cyc == 0) ? 8'ha1 : 8'hb2;
         @(negedge clk);
         exp_rdy = (sbq.size() < 4) || out_ready;
         exp_ov  = (sbq.size() > 0) && (edge_cnt - sbt[0] >= 3);
         if (cyc == 7) begin
            n_checks++; if (d4_occ !== 3'd2 || d4_in_ready !== 1'b1 || d4_out_data !== 8'ha1)
            begin n_fail++;
               $display("FAIL bubble_stalled: got occ=%0d in_ready=%b data=%h want 2 1 a1",
                        d4_occ, d4_in_ready, d4_out_data); end
         end
         n_checks++; if (d4_in_ready !== exp_rdy) begin n_fail++;
            $display("FAIL bubble_in_ready cyc %0d: got %b want %b", cyc, d4_in_ready, exp_rdy); end
         n_checks++; if (d4_out_valid !== exp_ov) begin n_fail++;
            $display("FAIL bubble_out_valid cyc %0d: got %b want %b", cyc, d4_out_valid, exp_ov); end
         if (exp_ov) begin
            n_checks++; if (d4_out_data !== sbq[0]) begin n_fail++;
               $display("FAIL bubble_out_data cyc %0d: got %h want %h", cyc, d4_out_data, sbq[0]); end
         end
         n_checks++; if (d4_occ !== 3'(sbq.size())) begin n_fail++;
            $display("FAIL bubble_occupancy cyc %0d: got %0d want %0d", cyc, d4_occ, sbq.size()); end
         push = in_valid && exp_rdy;
         pop  = exp_ov && out_ready;
         @(posedge clk); #1;
         if (pop) begin void'(sbq.pop_front()); void'(sbt.pop_front()); got++; end
         if (push) begin sbq.push_back(in_data); sbt.push_back(edge_cnt); end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_checks++; if (got != 2) begin n_fail++;
         $display("FAIL bubble_delivered: got %0d words want 2", got); end
   endtask

   task automatic test_flush();
      logic exp_rdy, exp_ov, push, pop;
      pulse_reset();
      for (int cyc = 0; cyc < 16; cyc++) begin
         out_ready = (cyc >= 7);
         flush     = (cyc == 6);
         in_valid  = (cyc < 4) || (cyc == 6);
         in_data   = (cyc < 4) ? 8'(9 + cyc) : 8'd13;
         @(negedge clk);
         exp_rdy = (sbq.size() < 4) || out_ready;
         exp_ov  = (sbq.size() > 0) && (edge_cnt - sbt[0] >= 3);
         if (cyc == 6) begin
            n_checks++; if (d4_occ !== 3'd4 || d4_in_ready !== 1'b0) begin n_fail++;
               $display("FAIL flush_full_before: got occ=%0d in_ready=%b want 4 0",
                        d4_occ, d4_in_ready); end
         end
         if (cyc == 7) begin
            n_checks++; if (d4_occ !== 3'd0 || d4_out_valid !== 1'b0) begin n_fail++;
               $display("FAIL flush_cleared: got occ=%0d out_valid=%b want 0 0",
                        d4_occ, d4_out_valid); end
         end
         n_checks++; if (d4_in_ready !== exp_rdy) begin n_fail++;
            $display("FAIL flush_in_ready cyc %0d: got %b want %b", cyc, d4_in_ready, exp_rdy); end
         n_checks++; if (d4_out_valid !== exp_ov) begin n_fail++;
            $display("FAIL flush_out_valid cyc %0d: got %b want %b", cyc, d4_out_valid, exp_ov); end
         if (exp_ov) begin
            n_checks++; if (d4_out_data !== sbq[0]) begin n_fail++;
               $display("FAIL flush_out_data cyc %0d: got %h want %h", cyc, d4_out_data, sbq[0]); end
         end
         n_checks++; if (d4_occ !== 3'(sbq.size())) begin n_fail++;
            $display("FAIL flush_occupancy cyc %0d: got %0d want %0d", cyc, d4_occ, sbq.size()); end
         push = in_valid && exp_rdy;
         pop  = exp_ov && out_ready;
         @(posedge clk); #1;
         if (pop) begin void'(sbq.pop_front()); void'(sbt.pop_front()); end
         if (flush) begin sbq.delete(); sbt.delete(); end
         else if (push) begin sbq.push_back(in_data); sbt.push_back(edge_cnt); end
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic exp_rdy [3];
      logic exp_ov  [3];
      logic push    [3];
      logic pop     [3];
      pulse_reset();
      for (int k = 0; k < 3; k++) begin rq[k].delete(); rt[k].delete(); end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 99) == 0);
         in_data   = 8'($urandom);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            exp_rdy[k] = (rq[k].size() < rdep(k)) || out_ready;
            exp_ov[k]  = (rq[k].size() > 0) && (edge_cnt - rt[k][0] >= rdep(k) - 1);
            n_checks++; if (r_in_ready[k] !== exp_rdy[k]) begin n_fail++;
               $display("FAIL rand_in_ready depth %0d cyc %0d: got %b want %b", rdep(k), cyc,
                        r_in_ready[k], exp_rdy[k]); end
            n_checks++; if (r_out_valid[k] !== exp_ov[k]) begin n_fail++;
               $display("FAIL rand_out_valid depth %0d cyc %0d: got %b want %b", rdep(k), cyc,
                        r_out_valid[k], exp_ov[k]); end
            if (exp_ov[k]) begin
               n_checks++; if (r_out_data[k] !== rq[k][0]) begin n_fail++;
                  $display("FAIL rand_out_data depth %0d cyc %0d: got %h want %h", rdep(k), cyc,
                           r_out_data[k], rq[k][0]); end
            end
            n_checks++; if (r_occ[k] !== 4'(rq[k].size()) || int'(r_occ[k]) > rdep(k)) begin
               n_fail++;
               $display("FAIL rand_occupancy depth %0d cyc %0d: got %0d want %0d", rdep(k), cyc,
                        r_occ[k], rq[k].size()); end
            push[k] = in_valid && exp_rdy[k] && !flush;
            pop[k]  = exp_ov[k] && out_ready;
         end
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            if (pop[k]) begin void'(rq[k].pop_front()); void'(rt[k].pop_front()); end
            if (flush) begin rq[k].delete(); rt[k].delete(); end
            else if (push[k]) begin rq[k].push_back(in_data); rt[k].push_back(edge_cnt); end
         end
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'd0;
      @(posedge clk); #1;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_bubble_collapse();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
